kpg_prefix_adder_pipe: RTL
==========================

# kpg_prefix_adder_pipe

Parametrised, pipelined parallel-prefix integer adder built on kill/propagate/generate (KPG) carry classification. Successor to the fixed 32-bit combinational KPG adder used inside the floating-point adder and multiplier datapaths. Generalised in width and pipeline depth, adds carry-in, carry-out, signed overflow and an elastic valid/ready handshake. Used for mantissa add/subtract and exponent arithmetic in the pipelined FPA/FPM units.

## Interface
- WIDTH, 32: operand width; power of two, 8..64.
- LPS, 2: prefix levels per pipeline register, 1..log2(WIDTH).
- Derived: NLEV = log2(WIDTH); NPS = ceil(NLEV/LPS); LAT = NPS + 2.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- op_sub  in  1  1 = A − B (only with KPG_ADDER_SUB_EN).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB.
- ovf  out  1  two's-complement overflow.

## Operation
- Stage 0 (input register): per-bit KPG code: k when a=b=0, g when a=b=1, p otherwise. Position −1 is cin (g if 1, k if 0). With subtract active, b is inverted and position −1 forced g.
- Prefix network: Kogge-Stone, NLEV levels; combine rule: upper p takes lower code, upper k/g dominates. Register after every LPS levels (final group may be shorter): NPS stages.
- Final stage: sum[i] = a[i]^b'[i]^carry[i−1]; cout = prefix code of bit WIDTH−1 is g; ovf = carry into MSB XOR carry out of MSB. a, b', cin carried alongside in the pipeline.
- Elastic pipeline: LAT stages, each with valid bit. Stage n loads when empty or stage n+1 loads; last stage advances when out_ready=1. in_ready = stage 0 empty or stage 0 advancing (combinational from out_ready through valid chain, no registered skid).
- Beat accepted when in_valid & in_ready; in-order, no reordering, no drop, no duplication.
- Bubbles collapse: empty stages fill under backpressure; full capacity LAT beats.
- Data registers of empty stages hold value (don't-care); only valid bits reset.

## Timing
- Reset: out_valid=0, all stage valids=0, sum=0, cout=0, ovf=0; in_ready=1 the cycle after reset deasserts.
- Latency: beat accepted at edge t appears with out_valid=1 after edge t+LAT−1 (visible LAT cycles after presentation) when no stall. WIDTH=32, LPS=2 → LAT=5.
- Throughput: one beat/cycle while out_ready=1.
- out_valid=1 with out_ready=0: sum/cout/ovf/out_valid held stable until accepted.
- Full (LAT valid beats, out_ready=0): in_ready=0; same cycle out_ready rises, in_ready=1 and new beat is accepted simultaneously with output pop.
- Reset mid-stream: all in-flight beats discarded; no out_valid pulse after reset.
- in_valid with in_ready=0: no acceptance; producer holds beat.

## Configuration
- KPG_ADDER_SUB_EN defined: op_sub honoured per beat, travels with beat; mixed add/sub streams allowed back-to-back.
- Not defined: op_sub port present but ignored (treated 0), no inverter logic; cout/ovf refer to addition only.

## Test plan
- WIDTH=32: a=0xFFFFFFFF, b=0, cin=1, out_ready=1 -> after 5 cycles sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- KPG_ADDER_SUB_EN: a=5, b=7, op_sub=1 -> sum=0xFFFFFFFE, cout=0; next beat a=7, b=5, op_sub=1 -> sum=2, cout=1.
- Backpressure: out_ready=0, stream 8 beats -> exactly 5 accepted, in_ready=0; raise out_ready -> 8 results in order, one per cycle, values unchanged.
- Reset mid-stream: 3 beats in flight, rst_n=0 one cycle -> out_valid stays 0, sum=0; next beat has correct result at LAT.
- Random 10k beats, WIDTH=8/LPS=1 and WIDTH=64/LPS=3, random in_valid/out_ready -> matches a+b+cin reference in order.

Source files
------------

// File: rtl/kpg_prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder on kill/propagate/generate carry codes with an elastic valid/ready pipeline.
// Optional macro KPG_ADDER_SUB_EN: honour op_sub per beat (A - B); undefined builds ignore op_sub.
module kpg_prefix_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int LPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NLEV = $clog2(WIDTH);
    localparam int NPS  = (NLEV + LPS - 1) / LPS;
    localparam int LAT  = NPS + 2;

    logic [LAT-1:0]   r_v;
    logic [LAT-1:0]   w_load;
    logic [LAT-1:0]   w_vin;

    logic [WIDTH-1:0] r_x [0:NPS];
    logic [WIDTH-1:0] r_g [0:NPS];
    logic [WIDTH-1:0] r_p [0:NPS];
    logic [NPS:0]     r_ci;

    logic [WIDTH-1:0] w_g [1:NPS];
    logic [WIDTH-1:0] w_p [1:NPS];

    logic [WIDTH-1:0] w_bp;
    logic             w_ci;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_unused_p;

`ifdef KPG_ADDER_SUB_EN
    // Subtract inverts B and forces the carry-in position to generate.
    always_comb begin
        w_bp = op_sub ? ~b : b;
        w_ci = op_sub | cin;
    end
`else
    logic w_unused_op_sub;
    assign w_unused_op_sub = op_sub;

    // Addition only: operands pass straight through.
    always_comb begin
        w_bp = b;
        w_ci = cin;
    end
`endif

    // Per-bit KPG codes; the carry-in is folded into bit 0 so log2(WIDTH) levels resolve every carry.
    always_comb begin
        w_g0    = a & w_bp;
        w_p0    = a ^ w_bp;
        w_g0[0] = (a[0] & w_bp[0]) | ((a[0] ^ w_bp[0]) & w_ci);
        w_p0[0] = 1'b0;
    end

    // Kogge-Stone levels, LPS of them between consecutive pipeline registers.
    always_comb begin
        for (int s = 1; s <= NPS; s++) begin
            w_g[s] = r_g[s-1];
            w_p[s] = r_p[s-1];
            for (int l = (s - 1) * LPS; (l < NLEV) && (l < s * LPS); l++) begin
                for (int i = WIDTH - 1; i >= (1 << l); i--) begin
                    w_g[s][i] = w_g[s][i] | (w_p[s][i] & w_g[s][i - (1 << l)]);
                    w_p[s][i] = w_p[s][i] & w_p[s][i - (1 << l)];
                end
            end
        end
    end

    // Final stage: resolved group generates are the carries out of each bit.
    always_comb begin
        w_sum  = r_x[NPS] ^ {r_g[NPS][WIDTH-2:0], r_ci[NPS]};
        w_cout = r_g[NPS][WIDTH-1];
        w_ovf  = r_g[NPS][WIDTH-1] ^ r_g[NPS][WIDTH-2];
    end

    assign w_unused_p = ^r_p[NPS];

    // A stage loads when it or any stage downstream of it has room, or the consumer pops.
    always_comb begin
        for (int n = 0; n < LAT; n++) begin
            w_load[n] = out_ready | (|(~r_v & ({LAT{1'b1}} << n)));
        end
        w_vin = {r_v[LAT-2:0], in_valid};
    end

    assign in_ready  = rst_n & w_load[0];
    assign out_valid = r_v[LAT-1];
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Valid chain and output registers; only these carry a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_v <= (r_v & ~w_load) | (w_vin & w_load);
            if (w_load[LAT-1] && r_v[LAT-2]) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    // Data registers move only with a valid beat, so empty stages keep their old contents.
    always_ff @(posedge clk) begin
        if (w_load[0] && in_valid) begin
            r_x[0]  <= a ^ w_bp;
            r_g[0]  <= w_g0;
            r_p[0]  <= w_p0;
            r_ci[0] <= w_ci;
        end
        for (int s = 1; s <= NPS; s++) begin
            if (w_load[s] && r_v[s-1]) begin
                r_x[s]  <= r_x[s-1];
                r_g[s]  <= w_g[s];
                r_p[s]  <= w_p[s];
                r_ci[s] <= r_ci[s-1];
            end
        end
    end

endmodule
